piero_scan: RTL

Parametrised, sequential successor to the team's 4-bit priority-encoder / BCD-decoder pair. Captures a W-bit request vector and emits the index of every set bit, one per handshake, highest priority first. Each emitted index is also decoded one-hot over LIMIT outputs, with an error flag when the index is outside the decoder range. Sits between request-collection logic and a downstream consumer using a valid/ready handshake.

---
 rtl/piero_pkg.sv | 22 ++
 rtl/piero_prio_enc.sv | 42 ++++
 rtl/piero_scan.sv | 138 +++++++++++++
 3 files changed

// File: rtl/piero_pkg.sv
// ---------------------------------------------------------------------------
// piero_pkg
// Shared types and helpers for the piero_scan priority scanner.
//   state_t        : scanner FSM states (IDLE, SCAN)
//   PRIO_*_FIRST   : values for the MSB_FIRST parameter
//   idx_width()    : index width for a W-bit vector ($clog2, never below 1)
// ---------------------------------------------------------------------------
package piero_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam bit PRIO_LSB_FIRST = 1'b0;
    localparam bit PRIO_MSB_FIRST = 1'b1;

    function automatic int idx_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piero_prio_enc.sv
// ---------------------------------------------------------------------------
// piero_prio_enc
// Combinational parametrised priority encoder.
// Parameters:
//   W         : input vector width
//   MSB_FIRST : 1 selects the highest set bit, 0 the lowest
// Ports:
//   vec (in,  W)  : request vector
//   idx (out, IW) : index of the priority bit (0 when vec is all-zero)
//   any (out, 1)  : at least one bit of vec is set
// ---------------------------------------------------------------------------
module piero_prio_enc
    import piero_pkg::*;
#(
    parameter int W         = 16,
    parameter bit MSB_FIRST = PRIO_MSB_FIRST,
    localparam int IW       = idx_width(W)
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          any
);

    // The loop direction is chosen so that the winning bit is the last one
    // assigned: walking upward leaves the highest set bit, downward the lowest.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        idx = '0;
        any = |vec;
        if (MSB_FIRST) begin
            for (int i = 0; i < W; i++) begin
                if (vec[i]) idx = IW'(i);
            end
        end else begin
            for (int i = W - 1; i >= 0; i--) begin
                if (vec[i]) idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/piero_scan.sv
// ---------------------------------------------------------------------------
// piero_scan
// Captures a W-bit request vector and emits the index of every set bit, one
// per valid/ready handshake, in priority order. Each index is also decoded
// one-hot over LIMIT outputs, with err raised for indices >= LIMIT.
// Optional feature macro: PIERO_SCAN_ABORT_EN (adds the abort input).
// Ports:
//   clk        (in,  1)     : clock
//   rst_n      (in,  1)     : synchronous active-low reset
//   load       (in,  1)     : capture vec_in (only honoured in IDLE)
//   vec_in     (in,  W)     : request vector
//   abort      (in,  1)     : drop the current scan (PIERO_SCAN_ABORT_EN only)
//   busy       (out, 1)     : high while scanning
//   out_valid  (out, 1)     : idx/onehot/err are valid
//   out_ready  (in,  1)     : consumer accepts the current index
//   idx        (out, IW)    : index of the current priority bit
//   onehot     (out, LIMIT) : one-hot decode of idx, zero when err
//   err        (out, 1)     : idx >= LIMIT, qualified by out_valid
//   done       (out, 1)     : pulse, last index accepted
//   empty      (out, 1)     : pulse, an all-zero vector was loaded
// ---------------------------------------------------------------------------
module piero_scan
    import piero_pkg::*;
#(
    parameter int W         = 16,
    parameter int LIMIT     = 10,
    parameter bit MSB_FIRST = PRIO_MSB_FIRST,
    localparam int IW       = idx_width(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     vec_in,
`ifdef PIERO_SCAN_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    idx,
    output logic [LIMIT-1:0] onehot,
    output logic             err,
    output logic             done,
    output logic             empty
);

    state_t           r_state;
    logic [W-1:0]     r_rem;
    logic             r_done;
    logic             r_empty;

    logic [IW-1:0]    w_idx;
    logic             w_any;
    logic [W-1:0]     w_mask;
    logic [W-1:0]     w_rem_next;
    logic             w_in_range;
    logic [LIMIT-1:0] w_onehot;
    logic             w_abort;

`ifdef PIERO_SCAN_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    piero_prio_enc #(
        .W         (W),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio_enc (
        .vec (r_rem),
        .idx (w_idx),
        .any (w_any)
    );

    // Remainder with the current priority bit removed. idx never exceeds W-1,
    // so the shift always lands inside the vector.
    assign w_mask     = {{(W-1){1'b0}}, 1'b1} << w_idx;
    assign w_rem_next = r_rem & ~w_mask;

    assign w_in_range = (32'(w_idx) < LIMIT);

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < LIMIT; i++) begin
            if (w_any && (32'(w_idx) == i)) w_onehot[i] = 1'b1;
        end
    end

    // The remainder is non-zero exactly while in SCAN, so out_valid can come
    // straight from the encoder's any flag.
    assign busy      = (r_state == SCAN);
    assign out_valid = w_any;
    assign idx       = w_idx;
    assign onehot    = w_onehot;
    assign err       = w_any && !w_in_range;
    assign done      = r_done;
    assign empty     = r_empty;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_done  <= 1'b0;
            r_empty <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_empty <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        if (vec_in != '0) begin
                            r_rem   <= vec_in;
                            r_state <= SCAN;
                        end else begin
                            r_empty <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // abort wins over a handshake in the same cycle
                    if (w_abort) begin
                        r_rem   <= '0;
                        r_state <= IDLE;
                    end else if (out_ready) begin
                        r_rem <= w_rem_next;
                        if (w_rem_next == '0) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
